// File: rtl/dkongjr_vram_pkg.sv
// Shared types and constants for the CPU-side tile-VRAM initiator.
package dkongjr_vram_pkg;

  typedef enum logic [1:0] {IDLE, ARB, STROBE, DONE} vram_state_t;

  localparam int unsigned ACC_CYC_DEF = 2;
  localparam int unsigned CNT_W       = 4;
  localparam logic [31:0] ZERO_BUS    = '0;

endpackage

// File: rtl/dkongjr_vram_wbuf.sv
// One-entry posted-write buffer; loads on a CPU write, empties when the drain access finishes.
module dkongjr_vram_wbuf
  import dkongjr_vram_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK_12M,
  input  logic              I_RST,
  input  logic              load,
  input  logic              drain_done,
  input  logic [ADDR_W-1:0] ab_in,
  input  logic [DATA_W-1:0] db_in,
  output logic              full,
  output logic [ADDR_W-1:0] buf_ab,
  output logic [DATA_W-1:0] buf_db
);

  always_ff @(posedge CLK_12M or posedge I_RST) begin
    if (I_RST) begin
      full   <= 1'b0;
      buf_ab <= ZERO_BUS[ADDR_W-1:0];
      buf_db <= ZERO_BUS[DATA_W-1:0];
    end else if (load) begin
      full   <= 1'b1;
      buf_ab <= ab_in;
      buf_db <= db_in;
    end else if (drain_done) begin
      full   <= 1'b0;
    end
  end

endmodule

// File: rtl/dkongjr_vram_cpu_if.sv
// CPU-side initiator for the tile-VRAM busy/strobe protocol.
// Optional posted writes: define DKJR_VRAM_POSTED_WR_EN.
module dkongjr_vram_cpu_if
  import dkongjr_vram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_CYC = ACC_CYC_DEF
) (
  input  logic              CLK_12M,
  input  logic              I_RST,
  input  logic [ADDR_W-1:0] I_CPU_AB,
  input  logic [DATA_W-1:0] I_CPU_DB,
  input  logic              I_CPU_CSn,
  input  logic              I_CPU_RDn,
  input  logic              I_CPU_WRn,
  output logic [DATA_W-1:0] O_CPU_DB,
  output logic              O_CPU_WAITn,
  input  logic              I_VRAMBUSYn,
  output logic [ADDR_W-1:0] O_VRAM_AB,
  output logic [DATA_W-1:0] O_VRAM_DB,
  output logic              O_VRAM_WRn,
  output logic              O_VRAM_RDn,
  input  logic [DATA_W-1:0] I_VRAM_DB
);

  vram_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              acc_wr, drain, held;
  logic              req, wr_req, cpu_pend, post_now, wait_req;
  logic [DATA_W-1:0] rd_reg;
  logic              wb_full;
  logic [ADDR_W-1:0] wb_ab;
  logic [DATA_W-1:0] wb_db;

`ifdef DKJR_VRAM_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
  logic wb_load, wb_done;

  assign wb_load = post_now;
  assign wb_done = (state == DONE) && drain;

  dkongjr_vram_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
    .CLK_12M    (CLK_12M),
    .I_RST      (I_RST),
    .load       (wb_load),
    .drain_done (wb_done),
    .ab_in      (I_CPU_AB),
    .db_in      (I_CPU_DB),
    .full       (wb_full),
    .buf_ab     (wb_ab),
    .buf_db     (wb_db)
  );
`else
  localparam bit POSTED = 1'b0;
  assign wb_full = 1'b0;
  assign wb_ab   = ZERO_BUS[ADDR_W-1:0];
  assign wb_db   = ZERO_BUS[DATA_W-1:0];
`endif

  assign req      = ~I_CPU_CSn & (~I_CPU_RDn ^ ~I_CPU_WRn);
  assign wr_req   = ~I_CPU_WRn;
  // held marks a CPU write already absorbed by the buffer, until the CPU drops it
  assign cpu_pend = req & ~held;

  always_comb begin
    state_nxt = state;
    post_now  = POSTED && (state == IDLE) && !wb_full && cpu_pend && wr_req;
    // a pending CPU cycle waits unless it is being posted or has finished in DONE
    wait_req  = cpu_pend && !post_now && !((state == DONE) && !drain);
    unique case (state)
      IDLE:   if (wb_full || (cpu_pend && !post_now)) state_nxt = ARB;
      ARB:    if (!drain && !req) state_nxt = IDLE;
              else if (I_VRAMBUSYn) state_nxt = STROBE;
      STROBE: if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:   if (drain || !req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign O_CPU_WAITn = I_RST | ~wait_req;
  assign O_CPU_DB    = (!I_CPU_CSn && !I_CPU_RDn) ? rd_reg : ZERO_BUS[DATA_W-1:0];

  always_ff @(posedge CLK_12M or posedge I_RST) begin
    if (I_RST) begin
      state      <= IDLE;
      cnt        <= '0;
      acc_wr     <= 1'b0;
      drain      <= 1'b0;
      held       <= 1'b0;
      rd_reg     <= ZERO_BUS[DATA_W-1:0];
      O_VRAM_AB  <= ZERO_BUS[ADDR_W-1:0];
      O_VRAM_DB  <= ZERO_BUS[DATA_W-1:0];
      O_VRAM_WRn <= 1'b1;
      O_VRAM_RDn <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE) drain <= wb_full;
      if (!req) held <= 1'b0;
      else if (post_now) held <= 1'b1;
      if (state == ARB && state_nxt == STROBE) begin
        acc_wr     <= drain | wr_req;
        O_VRAM_AB  <= drain ? wb_ab : I_CPU_AB;
        O_VRAM_DB  <= drain ? wb_db : (wr_req ? I_CPU_DB : ZERO_BUS[DATA_W-1:0]);
        O_VRAM_WRn <= ~(drain | wr_req);
        O_VRAM_RDn <= drain | wr_req;
        cnt        <= CNT_W'(ACC_CYC);
      end else if (state == STROBE) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          O_VRAM_WRn <= 1'b1;
          O_VRAM_RDn <= 1'b1;
          O_VRAM_DB  <= ZERO_BUS[DATA_W-1:0];
          if (!acc_wr) rd_reg <= I_VRAM_DB;
        end
      end
    end
  end

endmodule

// File: doc/dkongjr_vram_cpu_if.md
Name: dkongjr_vram_cpu_if

Overview:
- CPU-side initiator for the tile-VRAM port; the opposite end of the VRAM busy/strobe protocol.
- Decodes Z80 read/write cycles to the 1K VRAM window and defers them while the video side holds VRAM busy (O_VRAMBUSYn low).
- Drives the VRAM address, data and strobes, and holds the CPU in wait until the access completes.
- Sits between the CPU bus decode and the tile-VRAM module.

Parameters:
ADDR_W, 10, VRAM address width
DATA_W, 8, data bus width
ACC_CYC, 2, clock cycles a VRAM strobe is held low (1..15)

Ports:
CLK_12M  in  1  system clock
I_RST  in  1  asynchronous reset, active-high
I_CPU_AB  in  ADDR_W  CPU address (VRAM window offset)
I_CPU_DB  in  DATA_W  CPU write data
I_CPU_CSn  in  1  VRAM window select, active-low
I_CPU_RDn  in  1  CPU read strobe, active-low
I_CPU_WRn  in  1  CPU write strobe, active-low
O_CPU_DB  out  DATA_W  read data to CPU; 0 when not reading
O_CPU_WAITn  out  1  CPU wait request, active-low
I_VRAMBUSYn  in  1  video side busy, low = VRAM unavailable
O_VRAM_AB  out  ADDR_W  VRAM address
O_VRAM_DB  out  DATA_W  VRAM write data; 0 unless writing
O_VRAM_WRn  out  1  VRAM write strobe
O_VRAM_RDn  out  1  VRAM read strobe
I_VRAM_DB  in  DATA_W  VRAM read data

Behaviour:
- Clock and reset: single clock domain on posedge CLK_12M. I_RST high acts asynchronously and forces the reset values below.
- Reset values: state IDLE, O_CPU_WAITn=1, O_VRAM_WRn=1, O_VRAM_RDn=1, O_VRAM_AB=0, O_VRAM_DB=0, read register=0, O_CPU_DB=0.
- Request: req = ~I_CPU_CSn & (~I_CPU_RDn ^ ~I_CPU_WRn).
  - RDn and WRn both low is illegal: no access, WAITn stays 1.
- State machine:
  - IDLE: on req, go to ARB. O_CPU_WAITn goes low combinationally in the same cycle, so the CPU samples wait with no lost T-state.
  - ARB: sample I_VRAMBUSYn each cycle.
    - If 1: latch address, data and direction; load the strobe counter with ACC_CYC; go to STROBE.
    - If 0: remain in ARB, unbounded.
  - STROBE: the selected strobe (registered output) is low for exactly ACC_CYC cycles.
    - Reads: I_VRAM_DB is captured on the final strobe cycle.
    - Strobes return high on entry to DONE.
    - Busy falling during STROBE is ignored; the access completes.
  - DONE: O_CPU_WAITn=1. Hold until req drops, then go to IDLE.
    - A new req is only recognised after a drop, so one CPU cycle produces exactly one VRAM access.
- Latency: req to WAITn release is at least ACC_CYC+2 cycles with the VRAM idle. Each busy cycle seen in ARB adds one cycle.
- Request withdrawn in ARB (CSn high): return to IDLE, no access.
- Request withdrawn in STROBE: the access completes, then DONE exits immediately.
- O_CPU_DB = read register while ~CSn & ~RDn, else 0.
- Reset mid-access: strobes go high immediately and no partial write is retried.

Optional Feature:
DKJR_VRAM_POSTED_WR_EN:
- Defined:
  - Adds a one-entry write buffer. A write with the buffer empty loads it with no wait asserted (WAITn stays 1).
  - The buffer drains via ARB/STROBE when busy is high.
  - Any request while the buffer is full asserts WAITn until the drain completes.
  - A read while the buffer is full waits for the drain, so reads always see the written data.
- Undefined: writes block exactly like reads.

Decomposition:
- Package dkongjr_vram_pkg holds:
  - state enum (IDLE, ARB, STROBE, DONE)
  - ACC_CYC default
  - zero-bus constant
  - strobe-counter width (4)
- Optional sub-module dkongjr_vram_wbuf: posted-write buffer with full flag and drain handshake, instantiated only under the macro.

Test Plan:
- Write 0x3A5 <= 0x5C with I_VRAMBUSYn=1, ACC_CYC=2 -> WAITn low 4 cycles; WRn low exactly 2 cycles; AB=0x3A5, DB=0x5C during the strobe; WAITn high in DONE.
- Read 0x012 with I_VRAM_DB=0xA7 and busy held low 10 cycles -> no strobe during busy; RDn low 2 cycles after busy rises; O_CPU_DB=0xA7 while RDn is low; WAITn released 14 cycles after req.
- Busy falls in the 2nd STROBE cycle -> strobe still lasts 2 cycles; data is written correctly.
- I_RST pulsed in the 1st STROBE cycle of a write -> WRn=1 and WAITn=1 asynchronously; state IDLE; O_CPU_DB=0.
- RDn and WRn both low with CSn low -> no strobes; WAITn stays 1. CSn high with WRn low -> no access.
- Macro defined: two back-to-back writes 0x100<=0x11 and 0x101<=0x22 with busy low -> first causes no wait; second waits until busy rises and 0x11 drains, then drains 0x22 in turn.
